pc_fetch: RTL and testbench

Parametrised instruction-fetch front end: generates the fetch PC, drives a ready/valid request to instruction SRAM with variable latency, and buffers returned words with their PCs in a small FIFO for decode. It replaces the single-register PC with backpressure from decode, exception-over-branch redirect priority and discard of stale in-flight responses. It sits between the instruction SRAM port and the IF/ID stage.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/ibuf_fifo.sv | 93 +++++++++
 rtl/pc_fetch.sv | 105 ++++++++++
 tb/tb_pc_fetch.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

   typedef enum logic [1:0] {
      F_IDLE    = 2'd0,
      F_REQ     = 2'd1,
      F_WAIT    = 2'd2,
      F_DISCARD = 2'd3
   } fetch_state_t;

   localparam int PC_W       = 32;
   localparam int INST_W     = 32;
   localparam int INST_BYTES = INST_W / 8;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
   } ibuf_entry_t;

endpackage

// File: rtl/ibuf_fifo.sv
// Instruction buffer: small synchronous FIFO of {pc, inst} with flush.
// Entries are reset so the head reads zero out of reset.
module ibuf_fifo #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  logic [AW-1:0]            push_pc_i,
   input  logic [DW-1:0]            push_inst_i,
   output logic [AW-1:0]            head_pc_o,
   output logic [DW-1:0]            head_inst_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   logic [AW-1:0] pc_q   [DEPTH];
   logic [DW-1:0] inst_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic          do_push, do_pop;
   logic [DEPTH-1:0] wr_sel;

   // Flush wins over both push and pop.
   assign do_pop  = pop_i & (count_q != '0) & ~flush_i;
   assign do_push = push_i & ~flush_i & ((count_q != FULL) | do_pop);

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
      assign wr_sel[gi] = do_push && (wr_ptr_q == PW'(gi));
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]   <= '0;
            inst_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) begin
               pc_q[i]   <= push_pc_i;
               inst_q[i] <= push_inst_i;
            end
         end
      end
   end

   assign head_pc_o   = pc_q[rd_ptr_q];
   assign head_inst_o = inst_q[rd_ptr_q];
   assign count_o     = count_q;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push_i && !flush_i && !pop_i && count_q == FULL));

endmodule

// File: rtl/pc_fetch.sv
// Fetch front end: PC generation, single-outstanding SRAM request FSM with
// redirect/discard handling, and an instruction buffer toward decode.
module pc_fetch
   import fetch_pkg::*;
#(
   parameter int                ADDR_W     = 32,
   parameter int                DATA_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(32'h0000_0000),
   parameter int                IBUF_DEPTH = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              EXC_FLAG,
   input  logic [ADDR_W-1:0] EXC_VEC,
   input  logic              BRANCH_FLAG,
   input  logic [ADDR_W-1:0] BRANCH_TAR_ADDR,
   output logic              MEM_CE,
   output logic [ADDR_W-1:0] MEM_ADDR,
   input  logic              MEM_RDY,
   input  logic              MEM_RVALID,
   input  logic [DATA_W-1:0] MEM_RDATA,
   output logic              INST_VALID,
   output logic [DATA_W-1:0] INST,
   output logic [ADDR_W-1:0] INST_PC,
   input  logic              INST_READY
);

   localparam int STEP  = DATA_W / 8;
   localparam int CNT_W = $clog2(IBUF_DEPTH) + 1;
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(STEP - 1));
   localparam logic [CNT_W-1:0]  FULL       = CNT_W'(IBUF_DEPTH);

   fetch_state_t      state_q;
   logic [ADDR_W-1:0] fetch_pc_q;
   logic [ADDR_W-1:0] req_pc_q;
   logic [CNT_W-1:0]  count;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_tgt;
   logic              accept;
   logic              push;
   logic              pop;

   // Exception has priority over branch.
   assign redirect     = EXC_FLAG | BRANCH_FLAG;
   assign redirect_tgt = (EXC_FLAG ? EXC_VEC : BRANCH_TAR_ADDR) & ALIGN_MASK;

   // Issue only with a free slot, so the single outstanding response always fits.
   assign MEM_CE     = (state_q == F_REQ) && (count < FULL);
   assign MEM_ADDR   = fetch_pc_q;
   assign accept     = MEM_CE & MEM_RDY;
   assign push       = (state_q == F_WAIT) & MEM_RVALID & ~redirect;
   assign INST_VALID = (count != '0);
   assign pop        = INST_VALID & INST_READY;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= F_IDLE;
         fetch_pc_q <= RESET_VEC;
         req_pc_q   <= RESET_VEC;
      end else begin
         case (state_q)
            F_IDLE: state_q <= F_REQ;
            F_REQ: begin
               if (accept) begin
                  req_pc_q <= fetch_pc_q;
                  // A request accepted alongside a redirect is already stale.
                  state_q  <= redirect ? F_DISCARD : F_WAIT;
               end
            end
            F_WAIT: begin
               if (MEM_RVALID)    state_q <= F_REQ;
               else if (redirect) state_q <= F_DISCARD;
            end
            F_DISCARD: begin
               if (MEM_RVALID) state_q <= F_REQ;
            end
            default: state_q <= F_IDLE;
         endcase

         if (redirect)    fetch_pc_q <= redirect_tgt;
         else if (accept) fetch_pc_q <= fetch_pc_q + ADDR_W'(STEP);
      end
   end

   ibuf_fifo #(
      .DEPTH (IBUF_DEPTH),
      .AW    (ADDR_W),
      .DW    (DATA_W)
   ) u_ibuf (
      .clk         (CLK),
      .rst_n       (RST),
      .push_i      (push),
      .pop_i       (pop),
      .flush_i     (redirect),
      .push_pc_i   (req_pc_q),
      .push_inst_i (MEM_RDATA),
      .head_pc_o   (INST_PC),
      .head_inst_o (INST),
      .count_o     (count)
   );

   a_addr_hold: assert property (@(posedge CLK) disable iff (!RST)
      (MEM_CE && !MEM_RDY && !redirect) |=> $stable(MEM_ADDR));

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: behavioural SRAM with configurable latency, scoreboard of
// expected {pc, inst} in buffer order, plus a second instance for PC wraparound.
module tb_pc_fetch;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        exc_flag, br_flag;
   logic [31:0] exc_vec, br_tar;
   logic        mem_ce, mem_rdy, mem_rvalid;
   logic [31:0] mem_addr, mem_rdata;
   logic        inst_valid, inst_ready;
   logic [31:0] inst, inst_pc;

   logic        w_mem_ce, w_rvalid, w_inst_valid;
   logic [31:0] w_mem_addr, w_rdata, w_inst, w_inst_pc;

   always #5 clk = ~clk;

   pc_fetch #(.ADDR_W(32), .DATA_W(32), .RESET_VEC(32'h0000_0000), .IBUF_DEPTH(4)) u_dut (
      .CLK(clk), .RST(rst_n),
      .EXC_FLAG(exc_flag), .EXC_VEC(exc_vec),
      .BRANCH_FLAG(br_flag), .BRANCH_TAR_ADDR(br_tar),
      .MEM_CE(mem_ce), .MEM_ADDR(mem_addr), .MEM_RDY(mem_rdy),
      .MEM_RVALID(mem_rvalid), .MEM_RDATA(mem_rdata),
      .INST_VALID(inst_valid), .INST(inst), .INST_PC(inst_pc), .INST_READY(inst_ready)
   );

   pc_fetch #(.ADDR_W(32), .DATA_W(32), .RESET_VEC(32'hFFFF_FFF8), .IBUF_DEPTH(4)) u_wrap (
      .CLK(clk), .RST(rst_n),
      .EXC_FLAG(1'b0), .EXC_VEC(32'h0),
      .BRANCH_FLAG(1'b0), .BRANCH_TAR_ADDR(32'h0),
      .MEM_CE(w_mem_ce), .MEM_ADDR(w_mem_addr), .MEM_RDY(1'b1),
      .MEM_RVALID(w_rvalid), .MEM_RDATA(w_rdata),
      .INST_VALID(w_inst_valid), .INST(w_inst), .INST_PC(w_inst_pc), .INST_READY(1'b1)
   );

   int n_checks = 0;
   int n_pass   = 0;

   ibuf_entry_t sb[$];
   logic [31:0] wpcs[$];
   logic [31:0] wdat[$];

   logic [31:0] exp_fetch_pc;
   logic        pend, pend_stale, resp_stale;
   int          pend_cnt;
   logic [31:0] pend_pc, pend_data, resp_pc;
   int          lat;
   logic        rdy_rand;
   logic        w_pend;
   logic [31:0] w_addr;
   int          pops, accepts;
   logic        last_accept;
   logic        cap_first;
   logic [31:0] first_pc;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, act, exp);
   endtask

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   // One clock: account for what the coming edge does, then advance and
   // present the memory response for the following edge.
   task automatic step();
      logic        redir;
      logic [31:0] tgt;
      ibuf_entry_t e;
      redir = exc_flag | br_flag;
      tgt   = (exc_flag ? exc_vec : br_tar) & ~32'(INST_BYTES - 1);
      last_accept = 1'b0;

      check("ivalid", inst_valid, sb.size() != 0);
      if (inst_valid && inst_ready && sb.size() != 0) begin
         e = sb.pop_front();
         check("inst_pc", inst_pc, e.pc);
         check("inst", inst, e.inst);
         $display("pop pc=%h inst=%h", inst_pc, inst);
         if (cap_first) begin
            first_pc  = inst_pc;
            cap_first = 1'b0;
         end
         pops++;
      end
      if (mem_ce && mem_rdy) begin
         check("mem_addr", mem_addr, exp_fetch_pc);
         pend        = 1'b1;
         pend_cnt    = lat;
         pend_pc     = exp_fetch_pc;
         pend_data   = data_of(mem_addr);
         pend_stale  = 1'b0;
         exp_fetch_pc = exp_fetch_pc + 32'(INST_BYTES);
         accepts++;
         last_accept = 1'b1;
      end
      if (mem_rvalid && !resp_stale && !redir) begin
         e.pc   = resp_pc;
         e.inst = mem_rdata;
         sb.push_back(e);
      end
      if (redir) begin
         sb.delete();
         exp_fetch_pc = tgt;
         if (pend) pend_stale = 1'b1;
      end

      if (w_inst_valid && wpcs.size() < 3) begin
         wpcs.push_back(w_inst_pc);
         wdat.push_back(w_inst);
      end
      if (w_mem_ce) begin
         w_pend = 1'b1;
         w_addr = w_mem_addr;
      end

      @(posedge clk);
      #1;

      mem_rvalid = 1'b0;
      if (pend) begin
         pend_cnt--;
         if (pend_cnt <= 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = pend_data;
            resp_pc    = pend_pc;
            resp_stale = pend_stale;
            pend       = 1'b0;
         end
      end
      mem_rdy  = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      w_rvalid = w_pend;
      w_rdata  = data_of(w_addr);
      w_pend   = 1'b0;
   endtask

   task automatic redirect_step(input logic e, input logic [31:0] ev, input logic b, input logic [31:0] bt);
      exc_flag = e;  exc_vec = ev;
      br_flag  = b;  br_tar  = bt;
      step();
      exc_flag = 1'b0;
      br_flag  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      rst_n = 1'b0;
      exc_flag = 1'b0; br_flag = 1'b0; exc_vec = '0; br_tar = '0;
      mem_rdy = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
      w_rvalid = 1'b0; w_rdata = '0; w_pend = 1'b0; w_addr = '0;
      inst_ready = 1'b1;
      exp_fetch_pc = 32'h0; pend = 1'b0; pend_stale = 1'b0; resp_stale = 1'b0;
      pend_cnt = 0; pend_pc = '0; pend_data = '0; resp_pc = '0;
      lat = 1; rdy_rand = 1'b0; pops = 0; accepts = 0;
      last_accept = 1'b0; cap_first = 1'b0; first_pc = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_ce", mem_ce, 0);
      check("rst_addr", mem_addr, 32'h0);
      check("rst_ivalid", inst_valid, 0);
      check("rst_inst", inst, 0);
      check("rst_inst_pc", inst_pc, 0);
      check("rst_wrap_addr", w_mem_addr, 32'hFFFF_FFF8);

      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("ce_idle", mem_ce, 0);
      step();
      check("ce_first", mem_ce, 1);

      // Zero-wait streaming: one instruction every two cycles.
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (pops > 0) found = 1;
      end
      check("first_pop_seen", found, 1);
      pops = 0;
      repeat (20) step();
      check("throughput", pops, 10);

      check("wrap_count", wpcs.size() >= 3, 1);
      if (wpcs.size() >= 3) begin
         check("wrap_pc0", wpcs[0], 32'hFFFF_FFF8);
         check("wrap_pc1", wpcs[1], 32'hFFFF_FFFC);
         check("wrap_pc2", wpcs[2], 32'h0000_0000);
         check("wrap_inst0", wdat[0], data_of(32'hFFFF_FFF8));
      end

      // Backpressure: buffer fills to depth, issue stops; one pop frees one request.
      inst_ready = 1'b0;
      repeat (20) step();
      check("fill_ce", mem_ce, 0);
      check("fill_ivalid", inst_valid, 1);
      check("fill_level", sb.size(), 4);
      accepts = 0;
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      repeat (8) step();
      check("refill_accepts", accepts, 1);
      check("refill_ce", mem_ce, 0);
      inst_ready = 1'b1;
      repeat (12) step();

      // Branch while waiting on a slow response.
      lat = 3;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         found = last_accept;
      end
      check("wait_accept", found, 1);
      cap_first = 1'b1;
      redirect_step(1'b0, 32'h0, 1'b1, 32'h0000_0100);
      check("br_addr", mem_addr, 32'h0000_0100);
      check("br_ivalid", inst_valid, 0);
      repeat (20) step();
      check("br_first_pc", first_pc, 32'h0000_0100);

      // Exception beats branch; redirect targets are word aligned.
      redirect_step(1'b1, 32'h0000_0180, 1'b1, 32'h0000_0200);
      check("exc_prio_addr", mem_addr, 32'h0000_0180);
      repeat (6) step();
      redirect_step(1'b0, 32'h0, 1'b1, 32'h0000_010A);
      check("align_addr", mem_addr, 32'h0000_0108);

      // Random ready, decode stalls and redirects against the scoreboard.
      lat = 2;
      rdy_rand = 1'b1;
      for (int i = 0; i < 150; i++) begin
         inst_ready = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0)
            redirect_step(1'($urandom_range(0, 1)), 32'h0000_0800 + 32'($urandom_range(0, 255)),
                          1'b1, 32'h0000_0400 + 32'($urandom_range(0, 255)));
         else
            step();
      end
      rdy_rand = 1'b0;
      inst_ready = 1'b1;
      repeat (12) step();

      // Asynchronous reset while waiting with two entries buffered.
      lat = 3;
      inst_ready = 1'b0;
      redirect_step(1'b0, 32'h0, 1'b1, 32'h0000_0040);
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         found = (sb.size() == 2) && pend;
      end
      check("rst_setup", found, 1);
      check("rst_setup_ivalid", inst_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_ce", mem_ce, 0);
      check("arst_ivalid", inst_valid, 0);
      check("arst_addr", mem_addr, 32'h0);
      check("arst_inst_pc", inst_pc, 0);
      sb.delete();
      pend = 1'b0; mem_rvalid = 1'b0; w_pend = 1'b0; w_rvalid = 1'b0;
      exp_fetch_pc = 32'h0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      inst_ready = 1'b1;
      cap_first = 1'b1;
      repeat (24) step();
      check("post_rst_first_pc", first_pc, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
